// File: rtl/way_hit_encoder.sv
// Registered one-hot to binary way encoder with valid/ready stage, lowest-index
// priority, multi-hit flag and sticky error. Optional counters: WAY_HIT_PERF_EN.
module way_hit_encoder #(
  parameter int WAYS  = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             enable,
  input  logic [WAYS-1:0]  hit_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] way_idx,
  output logic             hit,
  output logic             multi_hit,
  output logic             err_sticky,
  input  logic             err_clr
`ifdef WAY_HIT_PERF_EN
  ,
  output logic [15:0]      hit_cnt,
  output logic [15:0]      miss_cnt
`endif
);

  generate
    if ((IDX_W != $clog2(WAYS)) || (WAYS < 2) || (WAYS > 16) || ((WAYS & (WAYS - 1)) != 0)) begin : g_param_err
      $error("way_hit_encoder: WAYS must be a power of two in 2..16 and IDX_W = log2(WAYS)");
    end
  endgenerate

  // Lowest set bit wins: scan from the top so the last match is the smallest index.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [WAYS-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = {IDX_W{1'b0}};
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = i[IDX_W-1:0];
      end
    end
    return idx;
  endfunction

  function automatic logic more_than_one(input logic [WAYS-1:0] v);
    return |(v & (v - {{(WAYS-1){1'b0}}, 1'b1}));
  endfunction

  logic             out_valid_r;
  logic [IDX_W-1:0] way_idx_r;
  logic             hit_r;
  logic             multi_hit_r;
  logic             err_sticky_r;
  logic             accept_s;
  logic             transfer_s;
  logic [IDX_W-1:0] enc_idx_s;
  logic             enc_hit_s;
  logic             enc_multi_s;

  assign in_ready   = !out_valid_r || out_ready;
  assign accept_s   = in_valid && in_ready;
  assign transfer_s = out_valid_r && out_ready;

  // Encode the incoming vector; a disabled lookup is always a clean miss.
  always_comb begin
    enc_idx_s   = {IDX_W{1'b0}};
    enc_hit_s   = 1'b0;
    enc_multi_s = 1'b0;
    if (enable) begin
      enc_idx_s   = lowest_idx(hit_vec);
      enc_hit_s   = |hit_vec;
      enc_multi_s = more_than_one(hit_vec);
    end else begin
      enc_idx_s   = {IDX_W{1'b0}};
      enc_hit_s   = 1'b0;
      enc_multi_s = 1'b0;
    end
  end

  // Output stage: load on accept, drain on transfer, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      way_idx_r   <= {IDX_W{1'b0}};
      hit_r       <= 1'b0;
      multi_hit_r <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      way_idx_r   <= enc_idx_s;
      hit_r       <= enc_hit_s;
      multi_hit_r <= enc_multi_s;
    end else if (transfer_s) begin
      out_valid_r <= 1'b0;
    end
  end

  // Sticky error: an accepted multi-hit beats a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky_r <= 1'b0;
    end else if (accept_s && enc_multi_s) begin
      err_sticky_r <= 1'b1;
    end else if (err_clr) begin
      err_sticky_r <= 1'b0;
    end
  end

  assign out_valid  = out_valid_r;
  assign way_idx    = way_idx_r;
  assign hit        = hit_r;
  assign multi_hit  = multi_hit_r;
  assign err_sticky = err_sticky_r;

`ifdef WAY_HIT_PERF_EN
  logic [15:0] hit_cnt_r;
  logic [15:0] miss_cnt_r;

  // Saturating hit/miss counters, stepped per result handed to the data phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_r  <= 16'd0;
      miss_cnt_r <= 16'd0;
    end else if (transfer_s) begin
      if (hit_r) begin
        if (hit_cnt_r != 16'hFFFF) begin
          hit_cnt_r <= hit_cnt_r + 16'd1;
        end
      end else begin
        if (miss_cnt_r != 16'hFFFF) begin
          miss_cnt_r <= miss_cnt_r + 16'd1;
        end
      end
    end
  end

  assign hit_cnt  = hit_cnt_r;
  assign miss_cnt = miss_cnt_r;
`endif

endmodule

// File: tb/tb_way_hit_encoder.sv
// Scoreboard bench for way_hit_encoder: expectations are queued on accept and
// compared while the result is presented; counters checked with WAY_HIT_PERF_EN.
module tb_way_hit_encoder;

  typedef struct packed {
    logic [1:0] idx;
    logic       hit;
    logic       multi;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       enable;
  logic [3:0] hit_vec;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] way_idx;
  logic       hit;
  logic       multi_hit;
  logic       err_sticky;
  logic       err_clr;
`ifdef WAY_HIT_PERF_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  exp_t exp_q[$];
  logic mv;
  logic err_m;
  int   hc_m;
  int   mc_m;
  int   passed;
  int   total;

  way_hit_encoder #(.WAYS(4), .IDX_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .enable     (enable),
    .hit_vec    (hit_vec),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .way_idx    (way_idx),
    .hit        (hit),
    .multi_hit  (multi_hit),
    .err_sticky (err_sticky),
    .err_clr    (err_clr)
`ifdef WAY_HIT_PERF_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) passed++;
    else $error("FAIL %s: got=%0h expected=%0h", tag, got, want);
  endtask

  function automatic exp_t model(input logic en, input logic [3:0] v);
    exp_t e;
    e = '0;
    if (en && (v != 4'b0000)) begin
      e.hit   = 1'b1;
      e.multi = ($countones(v) > 1);
      if (v[0]) e.idx = 2'd0;
      else if (v[1]) e.idx = 2'd1;
      else if (v[2]) e.idx = 2'd2;
      else e.idx = 2'd3;
    end
    return e;
  endfunction

  // One clock: check the presented result, update the model, advance past the edge.
  task automatic cycle();
    logic acc;
    logic xfer;
    exp_t e;
    exp_t f;
    #1;
    chk("in_ready", in_ready, !mv || out_ready);
    xfer = mv && out_ready;
    acc  = in_valid && (!mv || out_ready);
    if (mv) begin
      chk("sb_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        f = exp_q[0];
        chk("way_idx", way_idx, f.idx);
        chk("hit", hit, f.hit);
        chk("multi_hit", multi_hit, f.multi);
      end
    end
    if (xfer && exp_q.size() > 0) begin
      f = exp_q.pop_front();
      if (f.hit) hc_m = (hc_m < 65535) ? hc_m + 1 : hc_m;
      else mc_m = (mc_m < 65535) ? mc_m + 1 : mc_m;
    end
    e = model(enable, hit_vec);
    if (acc) exp_q.push_back(e);
    if (acc && e.multi) err_m = 1'b1;
    else if (err_clr) err_m = 1'b0;
    mv = acc ? 1'b1 : (xfer ? 1'b0 : mv);
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, mv);
    chk("err_sticky", err_sticky, err_m);
  endtask

  task automatic check_reset_outputs();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_way_idx", way_idx, 2'd0);
    chk("rst_hit", hit, 1'b0);
    chk("rst_multi_hit", multi_hit, 1'b0);
    chk("rst_err_sticky", err_sticky, 1'b0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    mv    = 1'b0;
    err_m = 1'b0;
    hc_m  = 0;
    mc_m  = 0;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    model_reset();
    rst_n = 1'b0; in_valid = 1'b0; enable = 1'b0; hit_vec = 4'b0000;
    out_ready = 1'b0; err_clr = 1'b0;
    #12;
    check_reset_outputs();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // one-hot sweep at full throughput
    out_ready = 1'b1; enable = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      hit_vec = 4'b0001 << i;
      cycle();
    end
    in_valid = 1'b0; cycle();

    // disabled lookup and empty vector are misses
    in_valid = 1'b1; enable = 1'b0; hit_vec = 4'b1000; cycle();
    enable = 1'b1; hit_vec = 4'b0000; cycle();
    in_valid = 1'b0; cycle();

    // multi-hit priority and sticky error
    in_valid = 1'b1; hit_vec = 4'b1010; cycle();
    in_valid = 1'b0; cycle();
    err_clr = 1'b1; cycle();
    in_valid = 1'b1; hit_vec = 4'b0110; cycle();
    err_clr = 1'b0; in_valid = 1'b0; cycle();

    // backpressure then simultaneous transfer and accept
    in_valid = 1'b1; hit_vec = 4'b0100; cycle();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      hit_vec = 4'($urandom_range(15, 0));
      enable  = 1'($urandom_range(1, 0));
      cycle();
    end
    enable = 1'b1; out_ready = 1'b1; hit_vec = 4'b0001; cycle();
    in_valid = 1'b0; cycle();
    cycle();

    // random mix of handshakes, vectors and clears
    for (int i = 0; i < 60; i++) begin
      in_valid  = 1'($urandom_range(1, 0));
      out_ready = 1'($urandom_range(1, 0));
      enable    = ($urandom_range(3, 0) != 0);
      hit_vec   = 4'($urandom_range(15, 0));
      err_clr   = ($urandom_range(7, 0) == 0);
      cycle();
    end
    err_clr = 1'b0;

    // async reset while stalled with a multi-hit pending
    in_valid = 1'b1; enable = 1'b1; hit_vec = 4'b1100; out_ready = 1'b1; cycle();
    in_valid = 1'b0; out_ready = 1'b0; cycle();
    #2; rst_n = 1'b0; #1;
    check_reset_outputs();
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef WAY_HIT_PERF_EN
    out_ready = 1'b1; enable = 1'b1; in_valid = 1'b1;
    hit_vec = 4'b0001; cycle();
    hit_vec = 4'b0000; cycle();
    hit_vec = 4'b0100; cycle();
    enable = 1'b0; hit_vec = 4'b0010; cycle();
    enable = 1'b1; hit_vec = 4'b1000; cycle();
    in_valid = 1'b0; cycle();
    chk("hit_cnt_small", hit_cnt, 16'(hc_m));
    chk("miss_cnt_small", miss_cnt, 16'(mc_m));
    chk("hit_cnt_is_3", 32'(hc_m), 32'd3);
    in_valid = 1'b1; hit_vec = 4'b0001;
    for (int i = 0; i < 65540; i++) cycle();
    in_valid = 1'b0; cycle();
    chk("hit_cnt_sat", hit_cnt, 16'hFFFF);
    chk("miss_cnt_hold", miss_cnt, 16'(mc_m));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/way_hit_encoder.md
Name: way_hit_encoder

Overview:
- Registered 4-to-2 encoder for the phased cache.
- Converts the one-hot way-hit vector from the tag-compare phase into a binary way index for the data-array phase.
- Sits between tag compare and the data-phase way decoder, and is the inverse of that decoder's one-hot mapping.
- Adds a valid/ready pipeline stage, priority resolution, multi-hit detection and a sticky error flag.

Parameters:
- WAYS, 4, number of cache ways (power of two, 2..16).
- IDX_W, 2, index width; must equal log2(WAYS). Elaboration error otherwise.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  tag-phase result present.
- in_ready  out  1  stage can accept a result this cycle.
- enable  in  1  lookup enable; 0 forces a miss result.
- hit_vec  in  WAYS  per-way tag-match vector, bit i = way i.
- out_valid  out  1  registered result valid.
- out_ready  in  1  data phase consumes result.
- way_idx  out  IDX_W  encoded hit way.
- hit  out  1  at least one way matched (and enable=1).
- multi_hit  out  1  more than one way matched in this result.
- err_sticky  out  1  set by any accepted multi-hit; held until cleared.
- err_clr  in  1  synchronous clear of err_sticky.

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, way_idx=0, hit=0, multi_hit=0, err_sticky=0. Perf counters (if built) = 0.
- Release from reset is synchronous to clk.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept occurs when in_valid && in_ready.
  - Transfer out occurs when out_valid && out_ready.
- Latency: accepted result appears on outputs the cycle after acceptance (1 cycle).
- Full throughput: back-to-back accepts are allowed while out_ready=1.
- Output stability: while out_valid=1 && out_ready=0, way_idx/hit/multi_hit hold stable and in_ready=0.
- out_valid next state:
  - Set on accept.
  - Cleared on transfer without a simultaneous accept.
  - Simultaneous transfer and accept: out_valid stays 1 and the new result loads.
- Encoding (evaluated on accept):
  - enable=0: hit=0, way_idx=0, multi_hit=0, regardless of hit_vec.
  - enable=1, hit_vec=0: hit=0, way_idx=0, multi_hit=0.
  - enable=1, exactly one bit i set: hit=1, way_idx=i.
  - enable=1, two or more bits set: hit=1, way_idx = lowest set index, multi_hit=1.
  - Mapping for WAYS=4: 0001→0, 0010→1, 0100→2, 1000→3.
- err_sticky:
  - Set on the cycle after an accepted multi-hit.
  - err_clr=1 clears it.
  - err_clr coinciding with a multi-hit accept: set wins, err_sticky=1.
- hit_vec and enable are sampled only on accept; changes at other times are ignored.
- Reset mid-transfer: a pending result is discarded; out_valid drops immediately.

Optional Feature:
- Macro WAY_HIT_PERF_EN.
- Defined: adds outputs hit_cnt[15:0] and miss_cnt[15:0].
  - Increment on each transfer out (out_valid && out_ready) with hit=1 or hit=0 respectively.
  - Saturate at 16'hFFFF; no wrap.
  - Reset to 0 by rst_n; not affected by err_clr.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then one-hot sweep: out_ready=1, enable=1, hit_vec=0001,0010,0100,1000 on consecutive cycles → one cycle later way_idx=0,1,2,3, hit=1, multi_hit=0, out_valid=1 every cycle.
- Disable/miss: enable=0 with hit_vec=1000 → hit=0, way_idx=0. Then enable=1, hit_vec=0000 → hit=0, way_idx=0.
- Multi-hit priority: hit_vec=1010 → way_idx=1, hit=1, multi_hit=1, err_sticky=1 next cycle.
  - err_clr alone → err_sticky=0.
  - err_clr coincident with hit_vec=0110 accept → err_sticky stays 1, way_idx=1.
- Backpressure: accept 0100, hold out_ready=0 for 3 cycles while hit_vec toggles → in_ready=0, way_idx=2 held.
  - Then out_ready=1 with in_valid=1, hit_vec=0001 → transfer and accept in the same cycle; next cycle way_idx=0.
- Async reset mid-stall: out_valid=1, out_ready=0, pull rst_n low between edges → out_valid=0 and err_sticky=0 immediately, without waiting for a clock edge.
- With WAY_HIT_PERF_EN: 3 hits and 2 misses transferred → hit_cnt=3, miss_cnt=2.
  - Preload near saturation via 65540 hit transfers → hit_cnt=16'hFFFF.
